// File: rtl/lab62soc_button_ctrl.sv
// Push-button Avalon-MM slave: two-flop synchronizer, per-bit debounce,
// sticky press capture with W1C clear, and a maskable registered IRQ.
// Register map (word address): 0 stable, 1 mask, 2 edge (W1C), 3 raw sync2.
module lab62soc_button_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

  // Acceptance happens on the cycle the counter has reached this value
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ADDR_STABLE = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_RAW    = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_dly_q;
  db_state_e        st_q  [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];

  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] w1c_bits;
  logic [WIDTH-1:0] press_set;

  // Bits of writedata beyond the button count carry no meaning here
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  // --- stage: metastability guard; buttons idle high so flops reset to 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // --- stage: per-bit debounce FSM; a new level must persist until the
  // counter reaches CNT_MAX while in COUNTING, any glitch back restarts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= ST_STABLE;
        cnt_q[i] <= '0;
      end
      stable_q <= '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (st_q[i] == ST_STABLE) begin
          cnt_q[i] <= '0;
          if (sync2_q[i] != stable_q[i]) begin
            st_q[i] <= ST_COUNTING;
          end
        end else begin
          if (sync2_q[i] == stable_q[i]) begin
            st_q[i]  <= ST_STABLE;
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            stable_q[i] <= sync2_q[i];
            st_q[i]     <= ST_STABLE;
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Bus decode and press detection (high-to-low on the debounced level)
  always_comb begin
    wr_en     = chipselect & write;
    wr_bits   = writedata[WIDTH-1:0];
    w1c_bits  = (wr_en && (address == ADDR_EDGE)) ? wr_bits : '0;
    press_set = stable_dly_q & ~stable_q;
  end

  // Next-state for the software-visible registers; a press set beats a
  // simultaneous W1C on the same bit so no press is ever dropped
  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = wr_bits;
    end
    edge_d = (edge_q & ~w1c_bits) | press_set;
    irq_d  = |(edge_q & mask_q);
    unique case (address)
      ADDR_STABLE: readdata_d = 32'(stable_q);
      ADDR_MASK:   readdata_d = 32'(mask_q);
      ADDR_EDGE:   readdata_d = 32'(edge_q);
      ADDR_RAW:    readdata_d = 32'(sync2_q);
      default:     readdata_d = '0;
    endcase
  end

  // --- stage: edge capture, mask, IRQ and read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '1;
      edge_q       <= '0;
      mask_q       <= '0;
      irq_q        <= 1'b0;
      readdata_q   <= '0;
    end else begin
      stable_dly_q <= stable_q;
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_lab62soc_button_ctrl.sv
// Directed bench for lab62soc_button_ctrl with a short debounce window.
module tb_lab62soc_button_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  din;
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  lab62soc_button_ctrl #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle(input logic [1:0] a);
    address    = a;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = d;
    tick();
    bus_idle(a);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_idle(a);
    tick();
    d = readdata;
  endtask

  task automatic hold(input logic [1:0] lvl, input int n);
    in_port = lvl;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [31:0] rd;

    // Each row: inputs driven for one edge, outputs expected right after it
    vecs[0]  = '{2'b11, 2'd1, 1'b1, 1'b1, 32'h1,         32'h0, 1'b0};
    vecs[1]  = '{2'b11, 2'd1, 1'b0, 1'b0, 32'h0,         32'h1, 1'b0};
    vecs[2]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[3]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[4]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[5]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[6]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[7]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[8]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h3, 1'b0};
    vecs[9]  = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h2, 1'b0};
    vecs[10] = '{2'b10, 2'd2, 1'b0, 1'b0, 32'h0,         32'h1, 1'b1};
    vecs[11] = '{2'b10, 2'd3, 1'b0, 1'b0, 32'h0,         32'h2, 1'b1};
    vecs[12] = '{2'b10, 2'd2, 1'b1, 1'b1, 32'h1,         32'h1, 1'b1};
    vecs[13] = '{2'b10, 2'd2, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0};
    vecs[14] = '{2'b10, 2'd0, 1'b1, 1'b1, 32'h3,         32'h2, 1'b0};
    vecs[15] = '{2'b10, 2'd0, 1'b0, 1'b0, 32'h0,         32'h2, 1'b0};
    vecs[16] = '{2'b10, 2'd1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1, 1'b0};
    vecs[17] = '{2'b10, 2'd1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0};

    reset_n = 1'b0;
    in_port = 2'b11;
    bus_idle(2'd0);

    // Reset state
    tick(); tick(); tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    check("reset_stable", readdata, 32'h3);
    bus_read(2'd2, rd);
    check("reset_edge", rd, 32'h0);

    // Clean press, register reads, W1C, read-only write, upper-bit masking
    for (int i = 0; i < NVEC; i++) begin
      in_port    = vecs[i].din;
      address    = vecs[i].addr;
      chipselect = vecs[i].cs;
      write      = vecs[i].wr;
      writedata  = vecs[i].wd;
      tick();
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end
    bus_idle(2'd0);

    // Release must not capture an edge
    hold(2'b11, 10);
    bus_read(2'd2, rd);
    check("release_no_edge", rd, 32'h0);
    bus_read(2'd0, rd);
    check("release_stable", rd, 32'h3);

    // Bounce: low 3, high 1, then low; only the final run is accepted
    bus_idle(2'd0);
    for (int t = 0; t < 12; t++) begin
      in_port = (t == 3) ? 2'b11 : 2'b10;
      tick();
      check($sformatf("bounce_t%0d", t), readdata, (t >= 11) ? 32'h2 : 32'h3);
    end
    bus_read(2'd2, rd);
    check("bounce_edge", rd, 32'h1);
    bus_write(2'd2, 32'h1);
    for (int k = 0; k < 8; k++) tick();
    bus_read(2'd2, rd);
    check("bounce_edge_once", rd, 32'h0);

    // Set beats W1C on the same cycle
    bus_write(2'd1, 32'h3);
    hold(2'b11, 10);
    hold(2'b10, 10);
    bus_read(2'd2, rd);
    check("coll_pre_edge", rd, 32'h1);
    in_port = 2'b00;
    for (int k = 0; k < 7; k++) tick();
    address    = 2'd2;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = 32'h3;
    tick();
    check("coll_irq_n7", {31'b0, irq}, 32'h1);
    bus_idle(2'd2);
    tick();
    check("coll_edge", readdata, 32'h2);
    check("coll_irq_n8", {31'b0, irq}, 32'h1);
    tick();
    check("coll_irq_n9", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'h3);

    // Masking
    hold(2'b11, 10);
    hold(2'b10, 10);
    bus_write(2'd1, 32'h0);
    tick(); tick();
    check("mask_off_irq", {31'b0, irq}, 32'h0);
    address = 2'd1; chipselect = 1'b1; write = 1'b1; writedata = 32'h1;
    tick();
    check("mask_on_irq_w", {31'b0, irq}, 32'h0);
    bus_idle(2'd1);
    tick();
    check("mask_on_irq_w1", {31'b0, irq}, 32'h1);
    address = 2'd2; chipselect = 1'b1; write = 1'b1; writedata = 32'h1;
    tick();
    check("w1c_irq_c", {31'b0, irq}, 32'h1);
    bus_idle(2'd2);
    tick();
    check("w1c_irq_c1", {31'b0, irq}, 32'h0);

    // Reset during COUNTING
    hold(2'b11, 10);
    bus_idle(2'd0);
    hold(2'b10, 4);
    reset_n = 1'b0;
    #1;
    check("rmid_readdata", readdata, 32'h0);
    check("rmid_irq", {31'b0, irq}, 32'h0);
    check("rmid_stable", {30'b0, dut.stable_q}, 32'h3);
    check("rmid_cnt", {29'b0, dut.cnt_q[0]}, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t >= 6) check($sformatf("rmid_acc_t%0d", t), readdata, (t == 7) ? 32'h2 : 32'h3);
    end
    bus_read(2'd2, rd);
    check("rmid_edge", rd, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
